// File: rtl/button_step_gen.sv
`default_nettype none
// ============================================================================
// Module   : button_step_gen
// Purpose  : Synchronise and debounce a raw push-button into a clean level and
//            single-cycle step pulses. Define BUTTON_STEP_AUTO_REPEAT_EN to
//            build the auto-repeat (REPEAT state and repeat counter).
// Revision : 1.0 - initial release
// ============================================================================
module button_step_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic step_pulse,
    output logic held
);

    localparam int c_MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX_CNT = (c_MAX_A > REPEAT_PERIOD) ? c_MAX_A : REPEAT_PERIOD;
    localparam int CNT_W     = $clog2(c_MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync_q,   w_sync_d;
    logic [CNT_W-1:0]       r_db_cnt_q, w_db_cnt_d;
    logic                   r_level_q,  w_level_d;
    logic                   r_pulse_q,  w_pulse_d;
    logic                   r_held_q,   w_held_d;
    state_t                 r_state_q,  w_state_d;

    logic w_btn_s;
    logic w_rise;
    logic w_fall;

`ifdef BUTTON_STEP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_rpt_cnt_q, w_rpt_cnt_d;
`endif

    // Synchroniser and debounce: a change is accepted only after
    // DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
    always_comb begin
        w_sync_d   = {r_sync_q[SYNC_STAGES-2:0], btn_in};
        w_btn_s    = r_sync_q[SYNC_STAGES-1];
        w_level_d  = r_level_q;
        w_db_cnt_d = '0;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        if (w_btn_s != r_level_q) begin
            if (r_db_cnt_q == c_DB_LAST) begin
                w_level_d = w_btn_s;
                w_rise    = w_btn_s;
                w_fall    = ~w_btn_s;
            end else begin
                w_db_cnt_d = r_db_cnt_q + c_CNT_ONE;
            end
        end
    end

    // Release always wins over a repeat pulse due in the same cycle.
    always_comb begin
        w_state_d = r_state_q;
        w_pulse_d = 1'b0;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
        w_rpt_cnt_d = r_rpt_cnt_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_d = ST_PRESSED;
                    w_pulse_d = 1'b1;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
                    w_rpt_cnt_d = '0;
`endif
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_d = ST_IDLE;
                end
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
                else if (r_rpt_cnt_q == c_DELAY_LAST) begin
                    w_state_d   = ST_REPEAT;
                    w_pulse_d   = 1'b1;
                    w_rpt_cnt_d = '0;
                end else begin
                    w_rpt_cnt_d = r_rpt_cnt_q + c_CNT_ONE;
                end
`endif
            end
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (w_fall) begin
                    w_state_d = ST_IDLE;
                end else if (r_rpt_cnt_q == c_PERIOD_LAST) begin
                    w_pulse_d   = 1'b1;
                    w_rpt_cnt_d = '0;
                end else begin
                    w_rpt_cnt_d = r_rpt_cnt_q + c_CNT_ONE;
                end
            end
`endif
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_held_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q   <= '0;
            r_db_cnt_q <= '0;
            r_level_q  <= 1'b0;
            r_pulse_q  <= 1'b0;
            r_held_q   <= 1'b0;
            r_state_q  <= ST_IDLE;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
            r_rpt_cnt_q <= '0;
`endif
        end else begin
            r_sync_q   <= w_sync_d;
            r_db_cnt_q <= w_db_cnt_d;
            r_level_q  <= w_level_d;
            r_pulse_q  <= w_pulse_d;
            r_held_q   <= w_held_d;
            r_state_q  <= w_state_d;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
            r_rpt_cnt_q <= w_rpt_cnt_d;
`endif
        end
    end

    assign btn_level  = r_level_q;
    assign step_pulse = r_pulse_q;
    assign held       = r_held_q;

endmodule
`default_nettype wire
